// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store port (c_*)
// and a DMA/debug master (d_*). One beat is granted per cycle; the grant is
// combinational so an uncontended request completes in the same cycle.
// Read data is captured from the memory's combinational read port and is
// returned one cycle after the grant on the winner's rdata/rvalid outputs.
//
// Fairness: round-robin alternation when both request. A DMA beat issued
// with d_lock=1 enters a burst lock. During the lock, the DMA keeps the
// memory for at most MAX_BURST consecutive beats while the core waits, and
// then the core gets one beat.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   c_req/c_we/c_size/c_addr/c_wdata   core request fields
//   c_gnt, c_stall              core beat accepted / core waiting
//   c_rvalid, c_rdata           core read return (one cycle after grant)
//   d_req/d_we/d_size/d_addr/d_wdata   DMA request fields
//   d_lock                      DMA asks for a burst lock
//   d_gnt                       DMA beat accepted
//   d_rvalid, d_rdata           DMA read return (one cycle after grant)
//   m_we/m_size/m_addr/m_wdata  memory command, muxed from the winner
//   m_rdata                     memory combinational read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [2:0]        c_size,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_we,
    output logic [2:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    localparam logic [0:0] ST_RR   = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Arbitration state
    logic [0:0]        state_q, state_d;
    logic              last_q,  last_d;    // 0 = core won last, 1 = DMA
    logic [BW-1:0]     bcnt_q,  bcnt_d;

    // Read-return state
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q,  c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    logic              c_gnt_w, d_gnt_w;

    // -----------------------------------------------------------------------
    // Grant. Forced low during reset so no beat (and no write) can issue.
    // -----------------------------------------------------------------------
    always_comb begin
        c_gnt_w = 1'b0;
        d_gnt_w = 1'b0;
        if (!reset) begin
            if (state_q == ST_LOCK && d_req) begin
                // Lock: DMA owns the port until it has used its burst budget;
                // then the core gets a beat if it is waiting, otherwise the
                // DMA simply continues.
                if (bcnt_q < BMAX) begin
                    d_gnt_w = 1'b1;
                end else if (c_req) begin
                    c_gnt_w = 1'b1;
                end else begin
                    d_gnt_w = 1'b1;
                end
            end else if (c_req && d_req) begin
                // Contended round-robin: whoever did not win last time.
                if (last_q) begin
                    c_gnt_w = 1'b1;
                end else begin
                    d_gnt_w = 1'b1;
                end
            end else begin
                c_gnt_w = c_req;
                d_gnt_w = d_req;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: lock FSM, burst counter, last winner.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;

        if (c_gnt_w) begin
            last_d = 1'b0;
            bcnt_d = '0;
        end
        if (d_gnt_w) begin
            last_d = 1'b1;
        end

        case (state_q)
            ST_RR: begin
                // The beat that opens the lock already counts toward the
                // burst, so the core waits at most MAX_BURST DMA beats.
                if (d_gnt_w && d_lock) begin
                    state_d = ST_LOCK;
                    bcnt_d  = BW'(1);
                end
            end
            ST_LOCK: begin
                if (!d_req || (d_gnt_w && !d_lock)) begin
                    state_d = ST_RR;
                    bcnt_d  = '0;
                end else if (d_gnt_w) begin
                    bcnt_d = (bcnt_q == BMAX) ? BMAX : bcnt_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_RR;
                bcnt_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read return: capture memory data on a granted read; rvalid pulses for
    // the following cycle only. rdata holds until the next read.
    // -----------------------------------------------------------------------
    always_comb begin
        c_rvalid_d = c_gnt_w & ~c_we;
        d_rvalid_d = d_gnt_w & ~d_we;
        c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RR;
            last_q     <= 1'b1;     // core wins the first tie
            bcnt_q     <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            bcnt_q     <= bcnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. With no grant the memory sees the core fields but m_we is low.
    // -----------------------------------------------------------------------
    assign c_gnt    = c_gnt_w;
    assign d_gnt    = d_gnt_w;
    assign c_stall  = c_req & ~c_gnt_w;

    assign c_rvalid = c_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

    assign m_we    = (c_gnt_w & c_we) | (d_gnt_w & d_we);
    assign m_size  = d_gnt_w ? d_size  : c_size;
    assign m_addr  = d_gnt_w ? d_addr  : c_addr;
    assign m_wdata = d_gnt_w ? d_wdata : c_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we;
    logic [2:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic        c_gnt, c_stall, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_lock;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_we;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_gnt(c_gnt), .c_stall(c_stall),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_lock(d_lock), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Word memory model: combinational read, write at the clock edge.
    logic [31:0] mem [0:1023];
    assign m_rdata = mem[m_addr[11:2]];
    always @(posedge clk) if (m_we) mem[m_addr[11:2]] <= m_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_size = 3'd2; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_size = 3'd2; d_addr = 0; d_wdata = 0; d_lock = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        int stall_run, stall_max;
        logic exp_d [0:9];
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h404 >> 2] = 32'h12345678;
        mem[32'h600 >> 2] = 32'hCAFEF00D;

        // ---- reset behaviour: no grant, no write while reset is high
        idle_inputs();
        reset = 1;
        tick();
        c_req = 1; c_we = 1; d_req = 1; d_we = 1;
        #1;
        chk("rst_c_gnt", {31'b0, c_gnt}, 0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 0);
        chk("rst_m_we", {31'b0, m_we}, 0);
        tick();
        chk("rst_c_rvalid", {31'b0, c_rvalid}, 0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        do_reset();

        // ---- uncontended core read, data one cycle later
        c_req = 1; c_we = 0; c_addr = 32'h100;
        #1;
        chk("rd_c_gnt", {31'b0, c_gnt}, 1);
        chk("rd_m_addr", m_addr, 32'h100);
        tick();
        c_req = 0;
        chk("rd_c_rvalid", {31'b0, c_rvalid}, 1);
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_c_rvalid_off", {31'b0, c_rvalid}, 0);
        chk("rd_c_rdata_hold", c_rdata, 32'hDEADBEEF);

        // ---- both requesting, no lock: C, D, C, D; m_we follows winner
        do_reset();
        c_req = 1; c_we = 1; c_addr = 32'h400; c_wdata = 32'hA5A5A5A5;
        d_req = 1; d_we = 0; d_addr = 32'h404;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("alt_c_gnt%0d", k), {31'b0, c_gnt}, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("alt_d_gnt%0d", k), {31'b0, d_gnt}, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("alt_m_we%0d", k), {31'b0, m_we}, (k % 2 == 0) ? 1 : 0);
            tick();
            chk($sformatf("alt_d_rvalid%0d", k), {31'b0, d_rvalid}, (k % 2 == 1) ? 1 : 0);
        end
        chk("alt_d_rdata", d_rdata, 32'h12345678);
        chk("alt_c_rvalid", {31'b0, c_rvalid}, 0);

        // ---- locked DMA writes vs waiting core read: C DDDD C DDDD
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h500;
        d_req = 1; d_we = 1; d_lock = 1; d_addr = 32'h200; d_wdata = 32'h200;
        stall_run = 0; stall_max = 0;
        for (int k = 0; k < 10; k++) begin
            logic exp_dg;
            exp_dg = !(k == 0 || k == 5);
            #1;
            chk($sformatf("lock_d_gnt%0d", k), {31'b0, d_gnt}, {31'b0, exp_dg});
            chk($sformatf("lock_m_we%0d", k), {31'b0, m_we}, {31'b0, exp_dg});
            if (c_stall) stall_run++; else stall_run = 0;
            if (stall_run > stall_max) stall_max = stall_run;
            tick();
            if (exp_dg) begin
                d_addr = d_addr + 4;
                d_wdata = d_addr;
            end
        end
        chk("lock_stall_max", stall_max, 4);
        chk("lock_mem_200", mem[32'h200 >> 2], 32'h200);
        chk("lock_mem_21c", mem[32'h21C >> 2], 32'h21C);
        chk("lock_mem_220", mem[32'h220 >> 2], 32'h0);

        // ---- DMA locked alone for 10 beats, then the core arrives
        do_reset();
        d_req = 1; d_we = 1; d_lock = 1; d_addr = 32'h700; d_wdata = 32'h1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("solo_d_gnt%0d", k), {31'b0, d_gnt}, 1);
            tick();
        end
        c_req = 1; c_we = 0; c_addr = 32'h100;
        #1;
        chk("solo_c_gnt_now", {31'b0, c_gnt}, 1);
        chk("solo_m_we_core", {31'b0, m_we}, 0);
        tick();
        // counter cleared on the core grant: four DMA beats, then core again
        for (int k = 0; k < 5; k++) exp_d[k] = (k < 4);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("solo_after_d_gnt%0d", k), {31'b0, d_gnt}, {31'b0, exp_d[k]});
            tick();
        end

        // ---- reset one cycle after a locked DMA read grant
        do_reset();
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h600;
        #1;
        chk("rl_d_gnt0", {31'b0, d_gnt}, 1);
        tick();
        #1;
        chk("rl_d_gnt1", {31'b0, d_gnt}, 1);
        tick();
        reset = 1;
        #1;
        chk("rl_gnt_in_rst", {31'b0, d_gnt}, 0);
        chk("rl_we_in_rst", {31'b0, m_we}, 0);
        tick();
        reset = 0;
        chk("rl_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rl_d_rdata", d_rdata, 0);
        c_req = 1; c_we = 0; c_addr = 32'h100;
        #1;
        chk("rl_first_c_gnt", {31'b0, c_gnt}, 1);
        chk("rl_first_d_gnt", {31'b0, d_gnt}, 0);
        tick();
        idle_inputs();

        // ---- core write then read-back, back to back
        do_reset();
        c_req = 1; c_we = 1; c_addr = 32'h300; c_wdata = 32'h55;
        #1;
        chk("wr_c_gnt", {31'b0, c_gnt}, 1);
        chk("wr_m_we", {31'b0, m_we}, 1);
        tick();
        chk("wr_no_rvalid", {31'b0, c_rvalid}, 0);
        c_we = 0;
        #1;
        chk("rb_c_gnt", {31'b0, c_gnt}, 1);
        chk("rb_m_we", {31'b0, m_we}, 0);
        tick();
        c_req = 0;
        chk("rb_c_rvalid", {31'b0, c_rvalid}, 1);
        chk("rb_c_rdata", c_rdata, 32'h55);
        tick();
        chk("rb_c_rvalid_once", {31'b0, c_rvalid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the RISC-V core's load/store port and a DMA/debug master. It chooses one requester per cycle, drives `dmem` with the winner's write-enable, size, address and write data, and returns registered read data one cycle later. Round-robin fairness is bounded by a burst-lock counter: the DMA can hold the memory for at most `MAX_BURST` consecutive beats while the core is waiting. The block sits between `riscv` and `dmem` inside `top`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum consecutive DMA grants while the core is requesting (≥1)

Ports:
- `clk`  in  1  clock, single domain
- `reset`  in  1  synchronous, active-high
- `c_req`  in  1  core access request
- `c_we`  in  1  core write enable
- `c_size`  in  3  core access size, same encoding as `dmem` `memsize`
- `c_addr`  in  ADDR_W  core address
- `c_wdata`  in  DATA_W  core write data
- `c_gnt`  out  1  core access accepted this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`
- `c_rvalid`  out  1  core read data valid
- `c_rdata`  out  DATA_W  core read data
- `d_req`, `d_we`, `d_size`, `d_addr`, `d_wdata`  in  as core  DMA request fields
- `d_lock`  in  1  DMA requests a burst lock
- `d_gnt`  out  1  DMA access accepted this cycle
- `d_rvalid`  out  1  DMA read data valid
- `d_rdata`  out  DATA_W  DMA read data
- `m_we`  out  1  to `dmem` write enable
- `m_size`  out  3  to `dmem` size
- `m_addr`  out  ADDR_W  to `dmem` address
- `m_wdata`  out  DATA_W  to `dmem` write data
- `m_rdata`  in  DATA_W  from `dmem`, combinational read

## Operation
- Registered state:
  - `last`: last winner, 0 = core, 1 = DMA.
  - `state`: RR or LOCK.
  - `bcnt`: consecutive DMA grants, width `$clog2(MAX_BURST+1)`.
  - Read-return registers.
- Grant is combinational from the requests and registered state. A beat transfers when `req & gnt`.
- A requester holds `req` and all its fields stable until `gnt`.
- Exactly one of `c_gnt`/`d_gnt` is high when any request is present. Both are low when neither `req` is high.
- Arbitration in RR:
  - Single requester wins.
  - If both request, the one with `!= last` wins (alternation).
- Arbitration in LOCK:
  - DMA wins while `bcnt < MAX_BURST`.
  - Once `bcnt == MAX_BURST` and `c_req` is high, the core wins one beat.
  - If the core is idle, DMA keeps winning and `bcnt` saturates at `MAX_BURST`.
- FSM transitions:
  - RR→LOCK when a DMA beat is granted with `d_lock=1`.
  - LOCK→RR when `d_lock=0` at a DMA grant, or when `d_req=0`.
  - A core grant in LOCK leaves the state in LOCK and clears `bcnt` to 0.
- `bcnt`:
  - Increments on each DMA grant in LOCK, saturating.
  - Cleared on any core grant and on LOCK→RR.
- `last` updates to the winner on every grant.
- Memory drive:
  - `m_addr`/`m_size`/`m_wdata` mux the winner's fields; with no grant they carry the core fields.
  - `m_we = winner_we & (c_gnt|d_gnt)`, so it is never high without a grant.
- Reads:
  - On a granted read (`we=0`), `m_rdata` is captured into the winner's `*_rdata` register.
  - The matching `*_rvalid` is high for exactly the next cycle.
  - Writes produce no `rvalid`.
  - `*_rdata` holds its value until the next read to the same requester.
- Boundary cases:
  - Simultaneous core read plus DMA write, with core winning: the DMA write stalls. Only the core read is performed.
  - `MAX_BURST=1`: LOCK degenerates to strict alternation.
  - `d_lock` rising while core is mid-stall: takes effect only after the next DMA grant.
  - `reset` mid-burst: lock dropped, pending `rvalid` discarded.

## Timing
- Reset values:
  - `state`=RR, `last`=1 (core wins the first tie), `bcnt`=0.
  - `c_rvalid`=`d_rvalid`=0, `c_rdata`=`d_rdata`=0.
  - `m_we`=0 during reset regardless of requests.
  - `c_gnt`=`d_gnt`=0 during reset.
- Grant: zero-cycle, same cycle as `req` when uncontended.
- Write completes at the `clk` edge ending the grant cycle.
- Read latency: data valid one cycle after the grant.
- Throughput: one beat per cycle total. The core is stalled at most `MAX_BURST` consecutive cycles by DMA.
- No combinational path from `*_rdata`/`*_rvalid` to any input. `m_rdata` reaches outputs only through registers.

## Test plan
- After reset, `c_req=1` read from `0x100` (mem = `0xDEADBEEF`), `d_req=0` → `c_gnt=1` in cycle 0; `c_rvalid=1`, `c_rdata=0xDEADBEEF` in cycle 1.
- Both requesting continuously, `d_lock=0` → grants alternate C, D, C, D starting with the core; `m_we` follows each winner's `we`.
- `d_lock=1`, DMA writes `0x200..0x21C`, core requesting throughout, `MAX_BURST=4` → 4 DMA grants, 1 core grant, 4 DMA grants; `c_stall` never high more than 4 consecutive cycles.
- DMA locked alone for 10 beats, then `c_req` rises → core granted by the next cycle; `bcnt` saturated at 4 and cleared on the core grant.
- `reset` asserted one cycle after a DMA read grant in LOCK → `d_rvalid=0` next cycle, `state`=RR, first contended grant goes to the core.
- Core write `0x55` to `0x300` then core read from `0x300` in back-to-back granted cycles → `c_rdata=0x55`, exactly one `c_rvalid` pulse, no `rvalid` for the write.
